parity_checker: RTL and testbench

- Registered parity checker for a small code word whose parity bit is carried inside the word.
- Each valid input word is checked against even or odd parity, selected per word by `mode`.
- Drives a pass flag, a qualifying strobe and a sticky error flag.
- Sits at the receive side of a narrow link, ahead of error-handling logic.

---
 rtl/parity_checker.sv | 90 +++++++++
 tb/tb_parity_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/parity_checker.sv
// Registered parity checker for a code word that carries its own parity bit.
// Optional saturating failure counter and err_cnt port: define PARITY_ERR_CNT_EN.
module parity_checker #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    input  logic             valid,
    output logic             parity_ok,
    output logic             out_valid,
`ifdef PARITY_ERR_CNT_EN
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             err_sticky
);

    // Elaboration-time guard on the legal parameter ranges.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("parity_checker: WIDTH must be within 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("parity_checker: CNT_W must be at least 1");
    end

    logic word_p;
    logic word_ok;

    logic ok_q,     ok_d;
    logic vld_q,    vld_d;
    logic sticky_q, sticky_d;

    // Odd mode wants an odd number of ones (p=1); even mode wants p=0.
    assign word_p  = ^data_in;
    assign word_ok = mode ? word_p : ~word_p;

    always_comb begin
        ok_d     = ok_q;
        vld_d    = 1'b0;
        sticky_d = sticky_q;
        if (valid) begin
            ok_d  = word_ok;
            vld_d = 1'b1;
            if (!word_ok) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ok_q     <= 1'b0;
            vld_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            ok_q     <= ok_d;
            vld_q    <= vld_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at all-ones rather than wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (valid && !word_ok && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

    assign parity_ok  = ok_q;
    assign out_valid  = vld_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_checker.sv
// Scoreboard bench for parity_checker: directed words push expectations,
// a negedge monitor pops and compares on every out_valid.
module tb_parity_checker;

    localparam int WIDTH = 3;
    localparam int CNT_W = 2;
    localparam int EW    = 2 + CNT_W;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             mode;
    logic             valid;
    logic             parity_ok;
    logic             out_valid;
    logic             err_sticky;
    logic [CNT_W-1:0] cnt_act;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
    assign cnt_act = err_cnt;
`else
    assign cnt_act = '0;
`endif

    parity_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .mode       (mode),
        .valid      (valid),
        .parity_ok  (parity_ok),
        .out_valid  (out_valid),
`ifdef PARITY_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .err_sticky (err_sticky)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    logic             m_sticky = 1'b0;
    logic [CNT_W-1:0] m_cnt    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic ok);
        @(negedge clk);
        rst     = 1'b1;
        valid   = 1'b1;
        data_in = d;
        mode    = m;
        if (!ok) begin
            m_sticky = 1'b1;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        exp_q.push_back({ok, m_sticky, m_cnt});
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst   = 1'b1;
            valid = 1'b0;
        end
    endtask

    // A failing word rides on the reset edge and must be discarded.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        valid   = 1'b1;
        data_in = 3'b001;
        mode    = 1'b0;
        m_sticky = 1'b0;
        m_cnt    = '0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_parity_ok", {31'd0, parity_ok}, 32'd0);
        check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        check("rst_err_cnt", {30'd0, cnt_act}, 32'd0);
        rst   = 1'b1;
        valid = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [EW-1:0] e;
                int            ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("latency_cycle", cyc, ec);
                check("parity_ok", {31'd0, parity_ok}, {31'd0, e[EW-1]});
                check("err_sticky", {31'd0, err_sticky}, {31'd0, e[EW-2]});
`ifdef PARITY_ERR_CNT_EN
                check("err_cnt", {30'd0, cnt_act}, {30'd0, e[CNT_W-1:0]});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        valid   = 1'b1;
        data_in = 3'b000;
        mode    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_parity_ok", {31'd0, parity_ok}, 32'd0);
        check("init_out_valid", {31'd0, out_valid}, 32'd0);
        check("init_err_sticky", {31'd0, err_sticky}, 32'd0);
        check("init_err_cnt", {30'd0, cnt_act}, 32'd0);

        // First word right after release is checked; then pass/fail vectors back to back.
        send(3'b011, 1'b0, 1'b1);
        send(3'b001, 1'b0, 1'b0);
        send(3'b101, 1'b0, 1'b1);
        send(3'b111, 1'b1, 1'b1);
        send(3'b110, 1'b1, 1'b0);
        send(3'b000, 1'b0, 1'b1);
        send(3'b000, 1'b1, 1'b0);
        send(3'b111, 1'b0, 1'b0);
        send(3'b010, 1'b1, 1'b1);
        idle(2);

        // Hold on idle: inputs wander with valid low.
        send(3'b011, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("idle_parity_ok", {31'd0, parity_ok}, 32'd1);
                check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            end
            valid   = 1'b0;
            data_in = i[2:0];
            mode    = i[3];
        end

        // Clean state, then a mid-stream reset between two words.
        do_reset();
        send(3'b101, 1'b1, 1'b0);
        do_reset();
        send(3'b100, 1'b1, 1'b1);

        // Five failing words walk the counter into saturation.
        do_reset();
        for (int i = 0; i < 5; i++) send(3'b100, 1'b0, 1'b0);
        send(3'b110, 1'b0, 1'b1);
        do_reset();
        idle(3);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
